burst_delay_tx: RTL

//  Transmit side of the 34-bit burst word interface (Dout/EN) consumed by the burst delay

---
 rtl/afg_burst_pkg.sv | 16 +
 rtl/burst_gap_timer.sv | 31 +++
 rtl/burst_delay_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/afg_burst_pkg.sv
// Shared types and burst-word layout for the AFG burst delay datapath.
// Used by both the burst transmitter and the capture/delay side.
package afg_burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int FIRST_BIT = 33;
    localparam int LAST_BIT  = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_W   = 34;

endpackage

// File: rtl/burst_gap_timer.sv
// Loadable down-counter with a zero flag.
// Paces the idle gap between repeated bursts.
module burst_gap_timer #(
    parameter int W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/burst_delay_tx.sv
// Burst word transmitter: frames upstream samples into first/last
// tagged 34-bit words and paces repeated bursts with an idle gap.
module burst_delay_tx
    import afg_burst_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int GAP_W = 16,
    parameter int REP_W = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic [LEN_W-1:0]   Burst_Len,
    input  logic [GAP_W-1:0]   Gap,
    input  logic [REP_W-1:0]   Reps,
    input  logic [DATA_W-1:0]  Src_Data,
    input  logic               Src_Valid,
    output logic               Src_Ready,
    output logic [BURST_W-1:0] Dout,
    output logic               EN,
    output logic               Busy,
    output logic               Done
);

    state_t             state, state_n;
    logic [LEN_W-1:0]   len_q, word_cnt;
    logic [GAP_W-1:0]   gap_q;
    logic [REP_W-1:0]   reps_q, rep_cnt;
    logic [BURST_W-1:0] dout_q;
    logic               en_q, done_q;

    logic xfer, last_word, start_ok, zero_len, fin, load_gap, gap_zero;

    assign Src_Ready = (state == SEND);
    assign Busy      = (state != IDLE);
    assign Dout      = dout_q;
    assign EN        = en_q;
    assign Done      = done_q;

    assign last_word = (word_cnt == len_q - 1'b1);

    always_comb begin
        state_n  = state;
        xfer     = 1'b0;
        start_ok = 1'b0;
        zero_len = 1'b0;
        fin      = 1'b0;
        load_gap = 1'b0;
        if (Abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        if (Burst_Len != '0) begin
                            start_ok = 1'b1;
                            state_n  = SEND;
                        end else begin
                            zero_len = 1'b1;
                        end
                    end
                end
                SEND: begin
                    xfer = Src_Valid;
                    if (Src_Valid && last_word) begin
                        if (rep_cnt == reps_q) begin
                            fin     = 1'b1;
                            state_n = IDLE;
                        end else if (gap_q != '0) begin
                            load_gap = 1'b1;
                            state_n  = GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_zero) state_n = SEND;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= IDLE;
            len_q    <= '0;
            gap_q    <= '0;
            reps_q   <= '0;
            word_cnt <= '0;
            rep_cnt  <= '0;
            dout_q   <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_n;
            en_q   <= xfer;
            done_q <= fin | zero_len;
            if (xfer) begin
                dout_q[FIRST_BIT]    <= (word_cnt == '0);
                dout_q[LAST_BIT]     <= last_word;
                dout_q[DATA_W-1:0]   <= Src_Data;
            end
            if (Abort) begin
                word_cnt <= '0;
                rep_cnt  <= '0;
            end else if (start_ok) begin
                len_q    <= Burst_Len;
                gap_q    <= Gap;
                reps_q   <= Reps;
                word_cnt <= '0;
                rep_cnt  <= '0;
            end else if (xfer) begin
                if (last_word) begin
                    word_cnt <= '0;
                    // wraps to zero only on the final burst, so all-ones Reps is safe
                    rep_cnt  <= fin ? '0 : rep_cnt + 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    burst_gap_timer #(
        .W(GAP_W)
    ) u_gap_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (Abort),
        .load     (load_gap),
        .load_val (gap_q - 1'b1),
        .dec      (state == GAP),
        .zero     (gap_zero)
    );

endmodule
